param_deserializer: RTL and testbench
=====================================

Name: param_deserializer

Overview:
- Receive side of a parameterised bit-serial link: collects WIDTH serial bits into one parallel word, then presents it on a valid/ready output port.
- Sits downstream of a serializer, or of a parent module that drives serial data.
- Parent modules set WIDTH and bit order through named parameter override; the block must behave correctly for non-default values.

Parameters:
- WIDTH, 4, number of bits per assembled word (legal range 2..16).
- MSB_FIRST, 0, bit order: 0 = first received bit lands in word_out[0]; 1 = first received bit lands in word_out[WIDTH-1].

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block can accept a bit this cycle.
- word_out  output  WIDTH  assembled word.
- word_valid  output  1  word_out holds a complete word.
- word_ready  input  1  downstream accepts word_out this cycle.
- word_count  output  8  number of words handed off; wraps modulo 256.

Behaviour:
- Reset (rst=1 at posedge):
  - state=SHIFT, bit counter=0, shift register=0.
  - Outputs: word_out=0, word_valid=0, word_count=0.
  - bit_ready=1 in the first cycle after reset.
  - Reset wins over every other event in the same cycle, including a word handoff in progress.
- Bit transfer: a bit is taken when bit_valid && bit_ready at posedge. Word transfer: a word is taken when word_valid && word_ready at posedge.
- SHIFT state:
  - bit_ready=1, word_valid=0.
  - Each taken bit is written to position cnt (MSB_FIRST=0) or WIDTH-1-cnt (MSB_FIRST=1). cnt then increments.
  - When the taken bit is bit number WIDTH (cnt==WIDTH-1): cnt resets to 0, state becomes HOLD, and word_valid=1 from the next cycle.
  - Latency: word_valid rises exactly 1 cycle after the posedge that takes the last bit.
- HOLD state:
  - word_valid=1. word_out is stable until handoff.
  - bit_ready = word_ready (combinational pass-through).
  - Handoff without a new bit: state becomes SHIFT and word_count increments.
  - Handoff with a new bit in the same cycle: the new bit becomes the first bit of the next word (cnt becomes 1). Zero bubble.
  - WIDTH back-to-back bits give one word every WIDTH cycles.
- word_out keeps its last value after handoff until overwritten by the next completed word. Bits are assembled in an internal shift register, never directly in word_out.
- Gaps: bit_valid may drop at any point; cnt holds and there is no timeout.
- word_count: 8-bit increment on each handoff; 255 to 0 wrap.
- The bit counter must be wide enough for WIDTH=16. All index arithmetic must be sized so WIDTH-1-cnt never underflows.
- word_ready while word_valid=0 is ignored.

Optional Feature:
- Macro: PARAM_DESER_ASSERT_EN.
- With the macro defined, the block contains these assert property checks:
  - word_valid implies cnt==0 or cnt==1;
  - cnt < WIDTH always;
  - !word_valid implies bit_ready;
  - word_out is unchanged across cycles with word_valid && !word_ready.
- Without the macro: no assertions are compiled. Ports and cycle behaviour are identical in both builds.

Test Plan:
1. Reset: rst=1 for 2 cycles with bit_valid=1, bit_in=1 → word_valid=0, word_out=0, word_count=0, bit_ready=1; no bits counted.
2. Defaults (WIDTH=4, LSB first), word_ready=1, bits 1,0,1,1 on 4 consecutive cycles → word_out=4'b1101 and word_valid=1 for exactly 1 cycle, one cycle after the 4th bit; word_count=1.
3. MSB_FIRST=1 override, same stream → word_out=4'b1011.
4. Backpressure with bit_valid=1 held:
   - word_ready=0 for 3 cycles after word completes → bit_ready=0, word_out stable, word_count unchanged.
   - Then word_ready=1 → the bit taken that cycle becomes word bit 0; the next word completes 3 cycles later with no bubble.
5. Reset mid-word after 2 bits taken → cnt=0; the next 4 bits 0,1,1,0 give word_out=4'b0110 and no leftover bits.
6. Override #(.WIDTH(8)), LSB first, stream 1,0,1,0,0,1,0,1 → word_out=8'hA5. 256 consecutive words → word_count wraps to 0.

Source files
------------

// File: rtl/param_deserializer.sv
// rtl/param_deserializer.sv - bit-serial to parallel word receiver with valid/ready word output
// Optional property checks: define PARAM_DESER_ASSERT_EN.
module param_deserializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [7:0]       word_count
);

    // One spare bit so WIDTH=16 and LAST-cnt both stay representable without wrap.
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_SHIFT, S_HOLD} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_word;
    logic [7:0]       r_count;

    logic             w_bit_take;
    logic             w_word_take;
    logic             w_last;
    logic [CW-1:0]    w_pos;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_shift_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SHIFT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_SHIFT: if (w_bit_take && w_last) w_state_next = S_HOLD;
            S_HOLD:  if (w_word_take)          w_state_next = S_SHIFT;
            default: w_state_next = S_SHIFT;
        endcase
    end

    // In HOLD a new bit is only accepted alongside the handoff, giving zero-bubble streaming.
    always_comb begin
        word_valid = (r_state == S_HOLD);
        bit_ready  = (r_state == S_SHIFT) || word_ready;
    end

    always_comb begin
        w_bit_take   = bit_valid && bit_ready;
        w_word_take  = word_valid && word_ready;
        w_last       = (r_cnt == LAST);
        w_pos        = (MSB_FIRST != 0) ? (LAST - r_cnt) : r_cnt;
        w_mask       = WIDTH'(1) << w_pos;
        w_shift_next = bit_in ? (r_shift | w_mask) : (r_shift & ~w_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_count <= '0;
        end else begin
            if (w_word_take) begin
                r_count <= r_count + 8'd1;
            end
            if (w_bit_take) begin
                r_shift <= w_shift_next;
                if (w_last) begin
                    r_cnt  <= '0;
                    r_word <= w_shift_next;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign word_out   = r_word;
    assign word_count = r_count;

`ifdef PARAM_DESER_ASSERT_EN
    a_hold_cnt: assert property (@(posedge clk) disable iff (rst)
        word_valid |-> (r_cnt == CW'(0) || r_cnt == CW'(1)));
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        r_cnt <= LAST);
    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
        !word_valid |-> bit_ready);
    a_word_stable: assert property (@(posedge clk) disable iff (rst)
        (word_valid && !word_ready) |=> $stable(word_out));
`endif

endmodule

// File: tb/tb_param_deserializer.sv
// tb/tb_param_deserializer.sv - randomized and directed check of param_deserializer against a word-level model
module tb_param_deserializer;

    logic       clk = 1'b0;
    logic [1:0] rst_g = 2'b11;
    logic [1:0] bi_g  = 2'b00;
    logic [1:0] bv_g  = 2'b00;
    logic [1:0] wr_g  = 2'b00;

    logic [3:0] wo_a, wo_b;
    logic [7:0] wo_c;
    logic [2:0] br, wv;
    logic [7:0] wc_a, wc_b, wc_c;

    int checks = 0;
    int errors = 0;

    int m_n[3], m_acc[3], m_word[3], m_cnt[3], m_total[3];
    bit m_v[3];
    int m_w[3]   = '{4, 4, 8};
    bit m_msb[3] = '{1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    param_deserializer dut_a (
        .clk(clk), .rst(rst_g[0]), .bit_in(bi_g[0]), .bit_valid(bv_g[0]), .bit_ready(br[0]),
        .word_out(wo_a), .word_valid(wv[0]), .word_ready(wr_g[0]), .word_count(wc_a));

    param_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst_g[0]), .bit_in(bi_g[0]), .bit_valid(bv_g[0]), .bit_ready(br[1]),
        .word_out(wo_b), .word_valid(wv[1]), .word_ready(wr_g[0]), .word_count(wc_b));

    param_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut_c (
        .clk(clk), .rst(rst_g[1]), .bit_in(bi_g[1]), .bit_valid(bv_g[1]), .bit_ready(br[2]),
        .word_out(wo_c), .word_valid(wv[2]), .word_ready(wr_g[1]), .word_count(wc_c));

    function automatic logic [15:0] obs_word(int d);
        case (d)
            0:       return {12'd0, wo_a};
            1:       return {12'd0, wo_b};
            default: return {8'd0, wo_c};
        endcase
    endfunction

    function automatic logic [15:0] obs_count(int d);
        case (d)
            0:       return {8'd0, wc_a};
            1:       return {8'd0, wc_b};
            default: return {8'd0, wc_c};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_n[d] = 0; m_acc[d] = 0; m_word[d] = 0; m_cnt[d] = 0; m_v[d] = 1'b0;
    endtask

    // Compare every output with the model, then advance model and DUTs by one clock.
    task automatic step();
        #1;
        for (int d = 0; d < 3; d++) begin
            int  g;
            bit  rdy, tw, tb;
            int  pos;
            g   = (d == 2) ? 1 : 0;
            rdy = !m_v[d] || wr_g[g];
            chk($sformatf("d%0d word_valid", d), {15'd0, wv[d]}, {15'd0, m_v[d]});
            chk($sformatf("d%0d bit_ready", d),  {15'd0, br[d]}, {15'd0, rdy});
            chk($sformatf("d%0d word_out", d),   obs_word(d),    16'(m_word[d]));
            chk($sformatf("d%0d word_count", d), obs_count(d),   16'(m_cnt[d]));
            if (rst_g[g]) begin
                model_reset(d);
            end else begin
                tw = m_v[d] && wr_g[g];
                tb = bv_g[g] && rdy;
                if (tw) begin
                    m_v[d]   = 1'b0;
                    m_cnt[d] = (m_cnt[d] + 1) % 256;
                    m_total[d]++;
                end
                if (tb) begin
                    pos = m_msb[d] ? (m_w[d] - 1 - m_n[d]) : m_n[d];
                    m_acc[d] += int'(bi_g[g]) * (1 << pos);
                    m_n[d]++;
                    if (m_n[d] == m_w[d]) begin
                        m_word[d] = m_acc[d];
                        m_v[d]    = 1'b1;
                        m_n[d]    = 0;
                        m_acc[d]  = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [3:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            bv_g[0] = 1'b1;
            bi_g[0] = bits[i];
            step();
        end
    endtask

    initial begin
        logic [3:0] s1, s5;
        logic [7:0] s6;
        int cycles;
        for (int d = 0; d < 3; d++) begin
            model_reset(d);
            m_total[d] = 0;
        end
        @(posedge clk);
        #1;

        // Reset with bits offered: nothing may be collected.
        rst_g = 2'b11; bv_g = 2'b11; bi_g = 2'b11; wr_g = 2'b00;
        step();
        step();
        rst_g = 2'b00; bv_g = 2'b00;
        #1;
        chk("reset word_valid", {15'd0, wv[0]}, 16'd0);
        chk("reset word_out",   {12'd0, wo_a}, 16'd0);
        chk("reset word_count", {8'd0, wc_a},  16'd0);
        chk("reset bit_ready",  {15'd0, br[0]}, 16'd1);
        for (int d = 0; d < 3; d++) for (int k = 0; k < 0; k++) ;
        m_total[0] = 0;

        // Stream 1,0,1,1 first bit first.
        wr_g[0] = 1'b1;
        s1 = 4'b1101;
        send0(s1, 4);
        chk("lsb word_out",   {12'd0, wo_a}, 16'h000D);
        chk("lsb word_valid", {15'd0, wv[0]}, 16'd1);
        chk("msb word_out",   {12'd0, wo_b}, 16'h000B);
        bv_g[0] = 1'b0;
        step();
        chk("single-cycle valid", {15'd0, wv[0]}, 16'd0);
        chk("count after word",   {8'd0, wc_a},  16'd1);

        // Backpressure with bits continuously offered.
        wr_g[0] = 1'b0;
        send0(4'($urandom), 4);
        for (int i = 0; i < 3; i++) begin
            bv_g[0] = 1'b1;
            bi_g[0] = 1'($urandom);
            step();
            chk("stall bit_ready", {15'd0, br[0]}, 16'd0);
            chk("stall count",     {8'd0, wc_a},  16'd1);
        end
        wr_g[0] = 1'b1;
        send0(4'($urandom), 4);
        chk("no-bubble valid", {15'd0, wv[0]}, 16'd1);
        bv_g[0] = 1'b0;
        step();

        // Reset after two bits, then a clean word.
        send0(4'b0011, 2);
        rst_g[0] = 1'b1;
        step();
        rst_g[0] = 1'b0;
        s5 = 4'b0110;
        send0(s5, 4);
        chk("post-reset word", {12'd0, wo_a}, 16'h0006);
        bv_g[0] = 1'b0;
        step();

        // WIDTH=8 directed word, then random traffic until the count wraps.
        wr_g[1] = 1'b1;
        s6 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            bv_g[1] = 1'b1;
            bi_g[1] = s6[i];
            step();
        end
        chk("w8 word_out",   {8'd0, wo_c},  16'h00A5);
        chk("w8 word_valid", {15'd0, wv[2]}, 16'd1);

        cycles = 0;
        while (m_total[2] < 256 && cycles < 20000) begin
            rst_g[0] = ($urandom_range(63) == 0);
            bv_g     = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
            bi_g     = 2'($urandom);
            wr_g     = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
            step();
            cycles++;
        end
        rst_g = 2'b00;
        chk("wrap budget", {15'd0, (cycles < 20000)}, 16'd1);
        chk("w8 count wrap", {8'd0, wc_c}, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
